// File: rtl/sumator_multibyte_ctrl.sv
// sumator_multibyte_ctrl: feeds an external 8-bit adder (sumator_8b) one byte
// per cycle, LSB first, and assembles an NBYTES-wide sum plus final carry.
// Operands arrive on a start valid/ready handshake; the result leaves on a
// result valid/ready handshake.
// Optional build macro: SUMATOR_OVERFLOW_EN adds the result_ovf output
// (signed two's-complement overflow of the wide sum).
module sumator_multibyte_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_carry_in,
  output logic [7:0]          add_in0,
  output logic [7:0]          add_in1,
  output logic                add_carry_in,
  input  logic [7:0]          add_out,
  input  logic                add_carry_out,
  output logic [8*NBYTES-1:0] result,
  output logic                result_carry,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy
`ifdef SUMATOR_OVERFLOW_EN
  ,
  output logic                result_ovf
`endif
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   idx;
  logic              carry_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [7:0]        a_byte;
  logic [7:0]        b_byte;
  logic              last_byte;

  // The index stops at NBYTES-1 because the FSM leaves ADD there.
  assign last_byte = (idx == IDXW'(NBYTES - 1));

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) begin
        a_byte = a_q[8*k +: 8];
        b_byte = b_q[8*k +: 8];
      end
    end
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/adder outputs, all decoded from the state.
  always_comb begin
    state_next   = state;
    start_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    add_in0      = '0;
    add_in1      = '0;
    add_carry_in = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        busy         = 1'b1;
        add_in0      = a_byte;
        add_in1      = b_byte;
        add_carry_in = carry_q;
        if (last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, then collect one adder byte per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      result_carry <= 1'b0;
`ifdef SUMATOR_OVERFLOW_EN
      result_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= op_carry_in;
            idx     <= '0;
            result  <= '0;
          end
        end
        ADD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDXW'(k)) begin
              result[8*k +: 8] <= add_out;
            end
          end
          carry_q <= add_carry_out;
          if (last_byte) begin
            result_carry <= add_carry_out;
`ifdef SUMATOR_OVERFLOW_EN
            result_ovf   <= (a_q[W-1] == b_q[W-1]) && (add_out[7] != a_q[W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumator_multibyte_ctrl.sv
// Self-checking bench for sumator_multibyte_ctrl with a behavioural 8-bit
// adder attached. Expected values come from whole-word arithmetic on the
// operands. Define SUMATOR_OVERFLOW_EN to also check result_ovf.
module tb_sumator_multibyte_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_carry_in;
  logic [7:0]   add_in0;
  logic [7:0]   add_in1;
  logic         add_carry_in;
  logic [7:0]   add_out;
  logic         add_carry_out;
  logic [W-1:0] result;
  logic         result_carry;
  logic         result_valid;
  logic         result_ready;
  logic         busy;
  logic [8:0]   add_sum;
`ifdef SUMATOR_OVERFLOW_EN
  logic         result_ovf;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for sumator_8b.
  assign add_sum = {1'b0, add_in0} + {1'b0, add_in1} + {8'b0, add_carry_in};
  assign add_out       = add_sum[7:0];
  assign add_carry_out = add_sum[8];

  sumator_multibyte_ctrl #(.NBYTES(NBYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_carry_in  (op_carry_in),
    .add_in0      (add_in0),
    .add_in1      (add_in1),
    .add_carry_in (add_carry_in),
    .add_out      (add_out),
    .add_carry_out(add_carry_out),
    .result       (result),
    .result_carry (result_carry),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
`ifdef SUMATOR_OVERFLOW_EN
    ,
    .result_ovf   (result_ovf)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [W-1:0] exp_result, input logic exp_carry);
    checkOutput({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    checkOutput({tag, "_result"}, 64'(result), 64'(exp_result));
    checkOutput({tag, "_result_carry"}, 64'(result_carry), 64'(exp_carry));
    checkOutput({tag, "_add_in0"}, 64'(add_in0), 64'd0);
    checkOutput({tag, "_add_in1"}, 64'(add_in1), 64'd0);
    checkOutput({tag, "_add_carry_in"}, 64'(add_carry_in), 64'd0);
  endtask

  // One full transaction: accept, NBYTES ADD cycles, hold DONE for 'hold' cycles, release.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input int hold);
    logic [W:0]   full;
    logic [W:0]   mask;
    logic [W:0]   part;
    logic [W-1:0] shifted;
    logic         exp_ovf;
    int           budget;
    full    = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    budget  = 0;
    while (!start_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!start_ready) begin
      checkOutput("start_ready_wait", 64'(start_ready), 64'd1);
    end
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    op_carry_in = cin;
    @(negedge clk);
    start_valid = 1'b0;
    op_a        = $urandom;
    op_b        = $urandom;
    op_carry_in = 1'($urandom_range(0, 1));
    for (int i = 0; i < NBYTES; i++) begin
      mask    = ((W+1)'(1) << (8 * i)) - (W+1)'(1);
      part    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(cin);
      checkOutput("add_busy", 64'(busy), 64'd1);
      checkOutput("add_start_ready", 64'(start_ready), 64'd0);
      checkOutput("add_result_valid", 64'(result_valid), 64'd0);
      shifted = a >> (8 * i);
      checkOutput("add_in0", 64'(add_in0), 64'(shifted[7:0]));
      shifted = b >> (8 * i);
      checkOutput("add_in1", 64'(add_in1), 64'(shifted[7:0]));
      checkOutput("add_carry_in", 64'(add_carry_in), 64'(part[8*i]));
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      checkOutput("done_result_valid", 64'(result_valid), 64'd1);
      checkOutput("done_busy", 64'(busy), 64'd1);
      checkOutput("done_start_ready", 64'(start_ready), 64'd0);
      checkOutput("done_result", 64'(result), 64'(full[W-1:0]));
      checkOutput("done_result_carry", 64'(result_carry), 64'(full[W]));
      checkOutput("done_add_in0", 64'(add_in0), 64'd0);
`ifdef SUMATOR_OVERFLOW_EN
      checkOutput("done_result_ovf", 64'(result_ovf), 64'(exp_ovf));
`endif
      if (h == hold) begin
        result_ready = 1'b1;
        start_valid  = 1'b0;
      end else begin
        result_ready = 1'b0;
        start_valid  = 1'b1;
        op_a         = $urandom;
        op_b         = $urandom;
      end
      @(negedge clk);
    end
    result_ready = 1'b0;
    start_valid  = 1'b0;
    checkIdle("release", full[W-1:0], full[W]);
`ifdef SUMATOR_OVERFLOW_EN
    checkOutput("release_result_ovf", 64'(result_ovf), 64'(exp_ovf));
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    op_a         = '0;
    op_b         = '0;
    op_carry_in  = 1'b0;
    result_ready = 1'b0;
    #12;
    checkIdle("reset", '0, 1'b0);
`ifdef SUMATOR_OVERFLOW_EN
    checkOutput("reset_result_ovf", 64'(result_ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h00FF00FF, 32'h00010001, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 3);

    // Reset in the middle of an addition, with the index at 2.
    start_valid = 1'b1;
    op_a        = 32'hDEADBEEF;
    op_b        = 32'h01234567;
    op_carry_in = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdle("midreset", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("postreset_result_valid", 64'(result_valid), 64'd0);
      checkOutput("postreset_start_ready", 64'(start_ready), 64'd1);
    end

    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1);
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 2);

    for (int n = 0; n < 25; n++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
